parallel_to_serial: RTL and testbench
=====================================

// Module: parallel_to_serial
// PURPOSE
//  Parallel-load, serial-out shifter used on the SPI slave's MISO return path.
//  Captures one DATA_WIDTH-bit word from the RAM/control side when load is asserted while idle.
//  Then drives the word out one bit per clk cycle, MSB first by default.
//  busy flags an active frame so the upstream controller knows when the next word can be accepted.
// PARAMETERS
//  DATA_WIDTH  8  width of parallel_in and of one serial frame (>=2)
//  MSB_FIRST   1  1: shift MSB first; 0: shift LSB first
// PORTS
//  clk          in   1           single clock; all state updates on rising edge
//  rst_n        in   1           reset, synchronous, active-low
//  parallel_in  in   DATA_WIDTH  word to serialise; sampled only on an accepted load
//  load         in   1           load request; level-sensitive, honoured only when busy==0
//  serial_out   out  1           serial data bit, registered
//  busy         out  1           1 while a frame is being shifted out, registered
// BEHAVIOUR
//  Interface: one clock, clk. Reset rst_n is synchronous and active-low.
//  Reset: rst_n==0 sampled at a rising edge has these effects:
//   - serial_out=0, busy=0, shift register=0, bit counter=0.
//   - Reset takes priority over load.
//   - Reset mid-frame aborts the frame immediately; no remaining bits are sent.
//  State: IDLE (busy=0) and SHIFT (busy=1), with a counter cnt of width clog2(DATA_WIDTH)+1.
//  IDLE, edge with load==1 (accept):
//   - serial_out <= first bit: parallel_in[DATA_WIDTH-1] if MSB_FIRST, else parallel_in[0].
//   - Shift reg <= the remaining DATA_WIDTH-1 bits of parallel_in.
//   - cnt <= DATA_WIDTH-1; busy <= 1.
//  IDLE, edge with load==0:
//   - Hold; serial_out <= 0 (idle line level 0).
//  SHIFT, edge with cnt!=0:
//   - serial_out <= next bit in order; shift register advances; cnt <= cnt-1.
//  SHIFT, edge with cnt==0:
//   - The last bit has been held for one cycle.
//   - busy <= 0; serial_out <= 0; go to IDLE.
//  Latency and frame timing:
//   - Bit k of the frame (k=0..DATA_WIDTH-1) is valid on serial_out during cycle k after the accepting edge.
//   - busy is high for exactly DATA_WIDTH cycles per frame.
//  Back-to-back and ignored inputs:
//   - load while busy==1 is ignored, including on the final-bit edge.
//   - load held high continuously therefore gives frames of DATA_WIDTH cycles separated by exactly 1 idle cycle (serial_out=0, busy=0).
//   - parallel_in changes while busy do not affect the frame in flight; the word is captured at acceptance.
//  Outputs depend only on registered state; there is no combinational path from inputs to outputs.
// TESTING
//  1. Reset then single load:
//     - Stimulus: rst_n=0 for 1 edge, then load=1 for 1 cycle with parallel_in=8'b10110101.
//     - Response: serial_out = 1,0,1,1,0,1,0,1 on successive cycles; busy=1 for 8 cycles, then busy=0, serial_out=0.
//  2. load held high, parallel_in=8'hB5 constant:
//     - Response: repeating 8-bit frames 10110101 each followed by 1 idle cycle (busy=0, serial_out=0).
//  3. Input change while busy:
//     - Stimulus: load 8'hF0, then change parallel_in to 8'h0F after 2 cycles.
//     - Response: output is still 11110000.
//  4. Reset mid-frame:
//     - Stimulus: load 8'hFF, assert rst_n=0 at the 4th bit.
//     - Response: next cycle serial_out=0, busy=0; no further bits.
//  5. MSB_FIRST=0, DATA_WIDTH=4:
//     - Stimulus: load 4'b0001.
//     - Response: serial_out = 1,0,0,0; busy high for 4 cycles.
//  6. Idle line and reset values:
//     - Stimulus: no load after reset for 10 cycles.
//     - Response: serial_out=0, busy=0 throughout; load pulses while busy never extend or corrupt a frame.

Source files
------------

// File: rtl/parallel_to_serial.sv
// Parallel-load, serial-out shifter for the SPI slave MISO return path.
// A word is captured on a load accepted while idle and is then driven out one
// bit per clock, MSB or LSB first. busy covers exactly DATA_WIDTH cycles.
module parallel_to_serial #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  load,
    output logic                  serial_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int SH_W  = DATA_WIDTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic              serial_out_q, serial_out_d;

    logic              first_bit;
    logic [SH_W-1:0]   rest_bits;
    logic              next_bit;
    logic [SH_W-1:0]   shreg_adv;

    // Bit-order selection: the first bit leaves immediately on acceptance,
    // the remaining DATA_WIDTH-1 bits wait in the shift register.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit = parallel_in[DATA_WIDTH-1];
            rest_bits = parallel_in[DATA_WIDTH-2:0];
            next_bit  = shreg_q[SH_W-1];
            shreg_adv = shreg_q << 1;
        end else begin
            first_bit = parallel_in[0];
            rest_bits = parallel_in[DATA_WIDTH-1:1];
            next_bit  = shreg_q[0];
            shreg_adv = shreg_q >> 1;
        end
    end

    // Next-state logic: accept when idle, shift while cnt!=0, then one cycle
    // holding the last bit before returning to idle with the line at 0.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        serial_out_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    serial_out_d = first_bit;
                    shreg_d      = rest_bits;
                    cnt_d        = CNT_W'(DATA_WIDTH - 1);
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    serial_out_d = next_bit;
                    shreg_d      = shreg_adv;
                    cnt_d        = cnt_q - CNT_W'(1);
                end else begin
                    serial_out_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            serial_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            serial_out_q <= serial_out_d;
        end
    end

    assign serial_out = serial_out_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: an 8-bit MSB-first instance and
// a 4-bit LSB-first instance, both compared every cycle against a frame model.
module tb_parallel_to_serial;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin0;
    logic       load0;
    logic       sout0, busy0;
    logic [3:0] pin1;
    logic       load1;
    logic       sout1, busy1;

    int unsigned n_total;
    int unsigned n_bad;
    int unsigned cyc;

    // Reference model per instance: frame word, bit index, cycles of busy left.
    logic [31:0] m_word [2];
    int          m_k    [2];
    int          m_left [2];
    logic        m_out  [2];

    parallel_to_serial #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .parallel_in(pin0), .load(load0),
        .serial_out(sout0), .busy(busy0)
    );

    parallel_to_serial #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .parallel_in(pin1), .load(load1),
        .serial_out(sout1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [31:0] w, input int k, input int width, input bit msb);
        logic [31:0] v;
        v = w;
        return msb ? v[width-1-k] : v[k];
    endfunction

    task automatic model_step(input int i, input logic ld, input logic [31:0] word);
        int  width;
        bit  msb;
        width = (i == 0) ? 8 : 4;
        msb   = (i == 0);
        if (!rst_n) begin
            m_left[i] = 0;
            m_out[i]  = 1'b0;
        end else if (m_left[i] == 0) begin
            if (ld) begin
                m_word[i] = word;
                m_k[i]    = 0;
                m_left[i] = width;
                m_out[i]  = frame_bit(word, 0, width, msb);
            end else begin
                m_out[i] = 1'b0;
            end
        end else begin
            m_left[i]--;
            m_k[i]++;
            m_out[i] = (m_left[i] != 0) ? frame_bit(m_word[i], m_k[i], width, msb) : 1'b0;
        end
    endtask

    // One clock: model advances on the edge, DUTs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0, load0, 32'(pin0));
        model_step(1, load1, 32'(pin1));
        @(negedge clk);
        cyc++;
        check_eq("ser8",  32'(sout0), 32'(m_out[0]));
        check_eq("busy8", 32'(busy0), 32'(m_left[0] != 0));
        check_eq("ser4",  32'(sout1), 32'(m_out[1]));
        check_eq("busy4", 32'(busy1), 32'(m_left[1] != 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc     = 0;
        for (int i = 0; i < 2; i++) begin
            m_word[i] = '0;
            m_k[i]    = 0;
            m_left[i] = 0;
            m_out[i]  = 1'b0;
        end
        rst_n = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        pin0  = 8'h00;
        pin1  = 4'h0;
        @(negedge clk);

        // Reset edge, then reset values on the line.
        run(1);
        rst_n = 1'b1;

        // Single 8'b10110101 load; 4-bit LSB-first instance loads 4'b0001.
        pin0  = 8'b1011_0101;
        load0 = 1'b1;
        pin1  = 4'b0001;
        load1 = 1'b1;
        run(1);
        load0 = 1'b0;
        load1 = 1'b0;
        run(11);

        // Load held high with constant word: frames separated by one idle cycle.
        pin0  = 8'hB5;
        load0 = 1'b1;
        load1 = 1'b1;
        run(30);
        load0 = 1'b0;
        load1 = 1'b0;
        run(10);

        // Input change while busy, plus load pulses during the frame.
        pin0  = 8'hF0;
        load0 = 1'b1;
        run(1);
        load0 = 1'b0;
        run(2);
        pin0  = 8'h0F;
        load0 = 1'b1;
        run(1);
        load0 = 1'b0;
        run(3);
        load0 = 1'b1;
        run(1);
        load0 = 1'b0;
        run(6);

        // Reset mid-frame aborts with no further bits.
        pin0  = 8'hFF;
        load0 = 1'b1;
        pin1  = 4'hF;
        load1 = 1'b1;
        run(1);
        load0 = 1'b0;
        load1 = 1'b0;
        run(2);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(10);

        // Idle line after reset: no load for 10 cycles.
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            pin0  = 8'($urandom);
            pin1  = 4'($urandom);
            load0 = ($urandom_range(0, 3) != 0);
            load1 = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
